// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and drives the instruction ROM read port.
// Returned words go into an instruction register with a valid/ready handshake.
//   state     | meaning
//   S_RESET   | one idle cycle after reset, no fetch issued
//   S_RUN     | streaming fetch, honours redirect and backpressure
//   S_DRAIN   | halt requested, waiting for the pending ROM word to be taken
//   S_HALTED  | fetch stopped until reset
module fetch_unit #(
   parameter int                DEPTH    = 1024,
   parameter int                AW       = 10,
   parameter logic [AW-1:0]     RESET_PC = '0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        rom_en_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   output logic [31:0] ir_o,
   output logic [31:0] ir_pc_o,
   output logic        ir_valid_o,
   input  logic        ir_ready_i,
   input  logic        redirect_i,
   input  logic [31:0] target_i,
   input  logic        halt_i,
   output logic        halted_o
);

   typedef enum logic [1:0] {S_RESET, S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          inflight_q, inflight_d;
   logic          rom_en_q, rom_en_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [31:0]   ir_q, ir_d;
   logic [AW-1:0] ir_pc_q, ir_pc_d;
   logic          ir_valid_q, ir_valid_d;
   logic          halted_q, halted_d;

   logic accept, consume;
   logic unused_target;

   assign unused_target = ^target_i[31:AW];
   assign accept        = !ir_valid_q || ir_ready_i;
   assign consume       = inflight_q && accept;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inflight_d = inflight_q;
      rom_en_d   = 1'b0;
      rom_addr_d = rom_addr_q;
      // rom_addr_q still names the word sitting on rom_data_i
      ir_d       = consume ? rom_data_i : ir_q;
      ir_pc_d    = consume ? rom_addr_q : ir_pc_q;
      ir_valid_d = consume || (ir_valid_q && !ir_ready_i);

      case (state_q)
         S_RESET: state_d = S_RUN;
         S_RUN: begin
            if (redirect_i) begin
               ir_d       = ir_q;
               ir_pc_d    = ir_pc_q;
               ir_valid_d = 1'b0;
               rom_addr_d = target_i[AW-1:0];
               rom_en_d   = 1'b1;
               pc_d       = target_i[AW-1:0] + AW'(1);
               inflight_d = 1'b1;
            end else if (!halt_i && (!inflight_q || consume)) begin
               rom_addr_d = pc_q;
               rom_en_d   = 1'b1;
               pc_d       = pc_q + AW'(1);
               inflight_d = 1'b1;
            end else begin
               inflight_d = inflight_q && !consume;
            end
            if (halt_i) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            inflight_d = inflight_q && !consume;
            if (!inflight_d) state_d = S_HALTED;
         end
         S_HALTED: ;
         default: state_d = S_RESET;
      endcase

      halted_d = (state_d == S_HALTED);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_RESET;
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         rom_en_q   <= 1'b0;
         rom_addr_q <= '0;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         rom_en_q   <= rom_en_d;
         rom_addr_q <= rom_addr_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         halted_q   <= halted_d;
      end
   end

   assign rom_en_o   = rom_en_q;
   assign rom_addr_o = {{(32-AW){1'b0}}, rom_addr_q};
   assign ir_o       = ir_q;
   assign ir_pc_o    = {{(32-AW){1'b0}}, ir_pc_q};
   assign ir_valid_o = ir_valid_q;
   assign halted_o   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural ROM (word i holds 0x100+i,
// latched on the negedge after a posedge that saw rom_en).
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        rom_en;
   logic [31:0] rom_addr;
   logic [31:0] rom_q;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect;
   logic [31:0] target;
   logic        halt;
   logic        halted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (rom_en) rom_q <= 32'h100 + rom_addr;

   fetch_unit dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .rom_en_o   (rom_en),
      .rom_addr_o (rom_addr),
      .rom_data_i (rom_q),
      .ir_o       (ir),
      .ir_pc_o    (ir_pc),
      .ir_valid_o (ir_valid),
      .ir_ready_i (ir_ready),
      .redirect_i (redirect),
      .target_i   (target),
      .halt_i     (halt),
      .halted_o   (halted)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".rom_en"},   32'(rom_en),   32'h0);
      chk({tag, ".rom_addr"}, rom_addr,      32'h0);
      chk({tag, ".ir"},       ir,            32'h0);
      chk({tag, ".ir_pc"},    ir_pc,         32'h0);
      chk({tag, ".ir_valid"}, 32'(ir_valid), 32'h0);
      chk({tag, ".halted"},   32'(halted),   32'h0);
   endtask

   initial begin
      rom_q    = 32'hDEAD_BEEF;
      reset    = 1'b1;
      ir_ready = 1'b1;
      redirect = 1'b0;
      target   = 32'h0;
      halt     = 1'b0;

      step();                                    // reset edge
      chk_zero("reset");
      reset = 1'b0;

      step();                                    // S_RESET idle cycle
      chk("sreset.rom_en", 32'(rom_en), 32'h0);

      step();                                    // first fetch
      chk("start.rom_en",   32'(rom_en),   32'h1);
      chk("start.rom_addr", rom_addr,      32'h0);
      chk("start.ir_valid", 32'(ir_valid), 32'h0);

      for (int i = 0; i < 5; i++) begin          // IR_PC 0..4, one per cycle
         step();
         chk("stream.ir_pc",    ir_pc,         32'(i));
         chk("stream.ir",       ir,            32'h100 + 32'(i));
         chk("stream.ir_valid", 32'(ir_valid), 32'h1);
         chk("stream.rom_addr", rom_addr,      32'(i + 1));
      end

      ir_ready = 1'b0;                           // stall while IR_PC=4
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall.rom_en",   32'(rom_en),   32'h0);
         chk("stall.rom_addr", rom_addr,      32'h5);
         chk("stall.ir_pc",    ir_pc,         32'h4);
         chk("stall.ir_valid", 32'(ir_valid), 32'h1);
      end
      ir_ready = 1'b1;

      for (int i = 5; i < 8; i++) begin
         step();
         chk("release.ir_pc", ir_pc, 32'(i));
         chk("release.ir",    ir,    32'h100 + 32'(i));
      end

      redirect = 1'b1; target = 32'h20;
      step();
      chk("redir.rom_addr", rom_addr,      32'h20);
      chk("redir.rom_en",   32'(rom_en),   32'h1);
      chk("redir.ir_valid", 32'(ir_valid), 32'h0);
      redirect = 1'b0;
      step();
      chk("redir.ir_pc",    ir_pc,         32'h20);
      chk("redir.ir",       ir,            32'h120);
      chk("redir.valid2",   32'(ir_valid), 32'h1);

      redirect = 1'b1; target = 32'hFFFF_F3FF;   // only low 10 bits matter -> 1023
      step();
      chk("wrap.rom_addr", rom_addr,      32'd1023);
      chk("wrap.ir_valid", 32'(ir_valid), 32'h0);
      redirect = 1'b0;
      step();
      chk("wrap.ir_pc0",   ir_pc,    32'd1023);
      chk("wrap.ir0",      ir,       32'h4FF);
      chk("wrap.rom_addr", rom_addr, 32'h0);
      step();
      chk("wrap.ir_pc1",   ir_pc,    32'h0);
      chk("wrap.ir1",      ir,       32'h100);
      step();
      chk("wrap.ir_pc2",   ir_pc,    32'h1);

      ir_ready = 1'b0;                           // word for addr 2 stays pending
      step();
      chk("hstall.rom_en", 32'(rom_en), 32'h0);
      halt = 1'b1;
      step();
      chk("halt.rom_en",   32'(rom_en), 32'h0);
      chk("halt.halted",   32'(halted), 32'h0);
      halt = 1'b0;
      step();
      chk("drain.rom_en",  32'(rom_en), 32'h0);
      chk("drain.ir_pc",   ir_pc,       32'h1);
      chk("drain.halted",  32'(halted), 32'h0);
      ir_ready = 1'b1;
      step();
      chk("drain.ir_pc2",    ir_pc,         32'h2);
      chk("drain.ir",        ir,            32'h102);
      chk("drain.ir_valid",  32'(ir_valid), 32'h1);
      chk("halted.halted",   32'(halted),   32'h1);
      chk("halted.rom_en",   32'(rom_en),   32'h0);
      redirect = 1'b1; target = 32'h40;
      step();
      chk("halted.ir_valid", 32'(ir_valid), 32'h0);
      chk("halted.rom_en2",  32'(rom_en),   32'h0);
      chk("halted.rom_addr", rom_addr,      32'h2);
      chk("halted.halted2",  32'(halted),   32'h1);
      redirect = 1'b0;
      step();
      chk("halted.rom_en3",  32'(rom_en),   32'h0);

      reset = 1'b1;                              // restart, then reset again mid-stall
      step();
      chk_zero("reset2");
      reset = 1'b0;
      step();
      step();
      chk("restart.rom_addr", rom_addr, 32'h0);
      step();
      chk("restart.ir_pc",    ir_pc,    32'h0);
      step();
      chk("restart.ir_pc1",   ir_pc,    32'h1);
      ir_ready = 1'b0;
      step();
      chk("mstall.rom_en",    32'(rom_en), 32'h0);
      reset = 1'b1;
      step();
      chk_zero("reset3");
      reset    = 1'b0;
      ir_ready = 1'b1;
      step();
      chk("refetch.idle",     32'(rom_en), 32'h0);
      step();
      chk("refetch.rom_en",   32'(rom_en), 32'h1);
      chk("refetch.rom_addr", rom_addr,    32'h0);
      step();
      chk("refetch.ir_pc",    ir_pc,       32'h0);
      chk("refetch.ir",       ir,          32'h100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
